// File: rtl/vtg_pkg.sv
// Shared timing types, presets and helpers for the raster timing generator.
package vtg_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        pol;
  } vtg_timing_t;

  localparam int unsigned VTG_H = 0;
  localparam int unsigned VTG_V = 1;

  // Index with VTG_H / VTG_V.
  localparam vtg_timing_t VTG_640x480_60 [2] = '{
    '{active: 640, fp: 16, sync: 96,  bp: 48, pol: 1'b0},
    '{active: 480, fp: 10, sync: 2,   bp: 33, pol: 1'b0}
  };

  localparam vtg_timing_t VTG_800x600_60 [2] = '{
    '{active: 800, fp: 40, sync: 128, bp: 88, pol: 1'b1},
    '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: 1'b1}
  };

  function automatic int unsigned total(vtg_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: wrapping position counter with active/sync region decode.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter vtg_timing_t Timing = '{active: 1, fp: 0, sync: 1, bp: 0, pol: 1'b0},
  localparam int unsigned Total = total(Timing),
  localparam int unsigned W     = $clog2(Total)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int unsigned SyncLo = Timing.active + Timing.fp;
  localparam int unsigned SyncHi = SyncLo + Timing.sync;

  logic [W-1:0] cnt_q;
  int unsigned  cnt_ext;

  assign cnt_ext = 32'(cnt_q);
  assign cnt     = cnt_q;
  assign last    = (cnt_ext == Total - 1);
  assign wrap    = step && last;
  assign active  = (cnt_ext < Timing.active);
  assign sync    = (cnt_ext >= SyncLo) && (cnt_ext < SyncHi);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= last ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de, coordinates and sof/eol markers.
// Define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  localparam vtg_timing_t HTiming =
    '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP, pol: H_SYNC_POL},
  localparam vtg_timing_t VTiming =
    '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP, pol: V_SYNC_POL},
  localparam int unsigned H_TOTAL = total(HTiming),
  localparam int unsigned V_TOTAL = total(VTiming),
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          pixelClk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          sof,
  output logic          eol
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_param_check
    $error("video_timing_gen: active and sync widths must be non-zero");
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, h_wrap, h_active, h_sync;
  logic          v_active, v_sync;
  logic          unused_v_last, unused_v_wrap;

  vtg_axis_counter #(
    .Timing (HTiming)
  ) u_h (
    .clk    (pixelClk),
    .rst    (rst),
    .step   (en),
    .cnt    (h_cnt),
    .last   (h_last),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  // Vertical advances once per line, on the horizontal wrap.
  vtg_axis_counter #(
    .Timing (VTiming)
  ) u_v (
    .clk    (pixelClk),
    .rst    (rst),
    .step   (h_wrap),
    .cnt    (v_cnt),
    .last   (unused_v_last),
    .wrap   (unused_v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  logic at_origin;
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge pixelClk) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      de    <= 1'b0;
      sof   <= 1'b0;
      eol   <= 1'b0;
      hsync <= ~H_SYNC_POL;
      vsync <= ~V_SYNC_POL;
    end else if (en) begin
      x     <= h_cnt;
      y     <= v_cnt;
      de    <= h_active && v_active;
      sof   <= at_origin;
      eol   <= h_last;
      hsync <= h_sync ? H_SYNC_POL : ~H_SYNC_POL;
      vsync <= v_sync ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  // Steps in the same edge that registers sof, so the first frame reads 1.
  always_ff @(posedge pixelClk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (en && at_origin) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: default 640x480 timing and a tiny raster.
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        sof;
    logic        eol;
    logic [15:0] x;
    logic [15:0] y;
  } out_t;

  logic clk;
  logic rst_a, en_a, rst_b, en_b;
  logic hsync_a, vsync_a, de_a, sof_a, eol_a;
  logic hsync_b, vsync_b, de_b, sof_b, eol_b;
  logic [9:0] x_a, y_a;
  logic [2:0] x_b, y_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned ka = 0;
  int unsigned kb = 0;
  logic [15:0] fcb = '0;

  out_t obs_a, obs_b;
  assign obs_a = {hsync_a, vsync_a, de_a, sof_a, eol_a, 6'd0, x_a, 6'd0, y_a};
  assign obs_b = {hsync_b, vsync_b, de_b, sof_b, eol_b, 13'd0, x_b, 13'd0, y_b};

  video_timing_gen u_a (
    .pixelClk (clk),
    .rst      (rst_a),
    .en       (en_a),
    .hsync    (hsync_a),
    .vsync    (vsync_a),
    .de       (de_a),
    .x        (x_a),
    .y        (y_a),
    .sof      (sof_a),
    .eol      (eol_a)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt_a)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE   (4),
    .H_FP       (1),
    .H_SYNC     (1),
    .H_BP       (1),
    .V_ACTIVE   (2),
    .V_FP       (1),
    .V_SYNC     (1),
    .V_BP       (1),
    .H_SYNC_POL (1'b1),
    .V_SYNC_POL (1'b1)
  ) u_b (
    .pixelClk (clk),
    .rst      (rst_b),
    .en       (en_b),
    .hsync    (hsync_b),
    .vsync    (vsync_b),
    .de       (de_b),
    .x        (x_b),
    .y        (y_b),
    .sof      (sof_b),
    .eol      (eol_b)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt_b)
`endif
  );

`ifndef VTG_FRAME_CNT_EN
  assign frame_cnt_a = '0;
  assign frame_cnt_b = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after k enabled edges since reset: they show raster position k-1.
  function automatic out_t model(input int unsigned k, input int unsigned ha, hf, hsw, hb,
                                 input int unsigned va, vf, vsw, vb, input bit hp, vp);
    out_t o;
    int unsigned ht, vt, pos, xx, yy;
    o = '0;
    if (k == 0) begin
      o.hs = ~hp;
      o.vs = ~vp;
      return o;
    end
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    pos = k - 1;
    xx  = pos % ht;
    yy  = (pos / ht) % vt;
    o.x   = 16'(xx);
    o.y   = 16'(yy);
    o.de  = (xx < ha) && (yy < va);
    o.hs  = ((xx >= ha + hf) && (xx < ha + hf + hsw)) ? hp : ~hp;
    o.vs  = ((yy >= va + vf) && (yy < va + vf + vsw)) ? vp : ~vp;
    o.sof = (xx == 0) && (yy == 0);
    o.eol = (xx == ht - 1);
    return o;
  endfunction

  function automatic out_t model_a(input int unsigned k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  function automatic out_t model_b(input int unsigned k);
    return model(k, 4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
  endfunction

  task automatic drive_a(input bit e, input bit r);
    en_a  = e;
    rst_a = r;
    @(posedge clk);
    #1;
    if (r) ka = 0;
    else if (e) ka++;
  endtask

  task automatic drive_b(input bit e, input bit r);
    out_t m;
    en_b  = e;
    rst_b = r;
    @(posedge clk);
    #1;
    if (r) begin
      kb  = 0;
      fcb = '0;
    end else if (e) begin
      kb++;
      m = model_b(kb);
      if (m.sof) fcb = fcb + 16'd1;
    end
  endtask

  task automatic test_reset;
    en_a = 1'b1; en_b = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ka = 0; kb = 0; fcb = '0;
    compared += 2;
    if (obs_a !== model_a(0)) begin
      mismatched++; $display("FAIL reset_a obs=%h exp=%h", obs_a, model_a(0));
    end
    if (obs_b !== model_b(0)) begin
      mismatched++; $display("FAIL reset_b obs=%h exp=%h", obs_b, model_b(0));
    end
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (obs_a !== model_a(0)) begin
      mismatched++; $display("FAIL reset_hold_a obs=%h exp=%h", obs_a, model_a(0));
    end
    en_a = 1'b1; en_b = 1'b1;
    @(posedge clk);
    #1;
    ka = 1; kb = 1;
    fcb = 16'd1;
    en_a = 1'b0; en_b = 1'b0;
    compared += 2;
    if ({x_a, y_a, de_a, sof_a} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL first_edge_a x=%0d y=%0d de=%b sof=%b exp 0 0 1 1", x_a, y_a, de_a, sof_a);
    end
    if (obs_b !== model_b(1)) begin
      mismatched++; $display("FAIL first_edge_b obs=%h exp=%h", obs_b, model_b(1));
    end
  endtask

  task automatic test_tiny_frame;
    int unsigned n_vs = 0, n_hs = 0, n_eol = 0, n_de = 0, n_sof = 0;
    for (int i = 0; i < 35; i++) begin
      drive_b(1'b1, 1'b0);
      compared++;
      if (obs_b !== model_b(kb)) begin
        mismatched++; $display("FAIL tiny_frame k=%0d obs=%h exp=%h", kb, obs_b, model_b(kb));
      end
      n_vs += 32'(vsync_b); n_hs += 32'(hsync_b); n_eol += 32'(eol_b);
      n_de += 32'(de_b);    n_sof += 32'(sof_b);
    end
    en_b = 1'b0;
    compared++;
    if ({n_vs, n_hs, n_eol, n_de, n_sof} !== {32'd7, 32'd5, 32'd5, 32'd8, 32'd1}) begin
      mismatched++;
      $display("FAIL tiny_counts vs=%0d hs=%0d eol=%0d de=%0d sof=%0d exp 7 5 5 8 1",
               n_vs, n_hs, n_eol, n_de, n_sof);
    end
  endtask

  task automatic test_tiny_random;
    for (int i = 0; i < 600; i++) begin
      drive_b($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      compared++;
      if (obs_b !== model_b(kb)) begin
        mismatched++; $display("FAIL tiny_random k=%0d obs=%h exp=%h", kb, obs_b, model_b(kb));
      end
    end
    en_b = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_default_lines;
    int unsigned n_de = 0, n_hs_low = 0;
    for (int i = 0; i < 1600; i++) begin
      drive_a(1'b1, 1'b0);
      compared++;
      if (obs_a !== model_a(ka)) begin
        mismatched++; $display("FAIL default_lines k=%0d obs=%h exp=%h", ka, obs_a, model_a(ka));
      end
      n_de += 32'(de_a);
      n_hs_low += 32'(!hsync_a);
    end
    en_a = 1'b0;
    compared++;
    if ({n_de, n_hs_low} !== {32'd1280, 32'd192}) begin
      mismatched++;
      $display("FAIL default_counts de=%0d hs_low=%0d exp 1280 192", n_de, n_hs_low);
    end
  endtask

  task automatic test_stall;
    // Position x=639, y=10 is raster index 10*800+639.
    while (ka < 8640) begin
      drive_a(1'b1, 1'b0);
      compared++;
      if (obs_a !== model_a(ka)) begin
        mismatched++; $display("FAIL stall_run k=%0d obs=%h exp=%h", ka, obs_a, model_a(ka));
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b0, 1'b0);
      compared++;
      if ({x_a, y_a, de_a, eol_a} !== {10'd639, 10'd10, 1'b1, 1'b0} || obs_a !== model_a(ka))
      begin
        mismatched++; $display("FAIL stall_hold obs=%h exp=%h", obs_a, model_a(ka));
      end
    end
    drive_a(1'b1, 1'b0);
    en_a = 1'b0;
    compared++;
    if ({x_a, de_a} !== {10'd640, 1'b0}) begin
      mismatched++; $display("FAIL stall_resume x=%0d de=%b exp 640 0", x_a, de_a);
    end
  endtask

  task automatic test_mid_reset;
    while (ka < 12 * 800 + 301) drive_a(1'b1, 1'b0);
    compared++;
    if ({x_a, y_a} !== {10'd300, 10'd12}) begin
      mismatched++; $display("FAIL mid_pos x=%0d y=%0d exp 300 12", x_a, y_a);
    end
    drive_a(1'b1, 1'b1);
    compared++;
    if ({x_a, y_a, de_a, sof_a, hsync_a, vsync_a} !== {10'd0, 10'd0, 4'b0011}) begin
      mismatched++;
      $display("FAIL mid_reset x=%0d y=%0d de=%b sof=%b hs=%b vs=%b exp 0 0 0 0 1 1",
               x_a, y_a, de_a, sof_a, hsync_a, vsync_a);
    end
    drive_a(1'b1, 1'b0);
    en_a = 1'b0;
    compared++;
    if ({x_a, y_a, de_a, sof_a} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL mid_restart x=%0d y=%0d de=%b sof=%b exp 0 0 1 1", x_a, y_a, de_a, sof_a);
    end
  endtask

`ifdef VTG_FRAME_CNT_EN
  task automatic test_frame_cnt;
    int unsigned budget;
    drive_b(1'b1, 1'b1);
    for (int i = 0; i < 70; i++) begin
      drive_b(1'b1, 1'b0);
      compared++;
      if (frame_cnt_b !== fcb) begin
        mismatched++; $display("FAIL frame_cnt k=%0d obs=%0d exp=%0d", kb, frame_cnt_b, fcb);
      end
    end
    compared++;
    if (frame_cnt_b !== 16'd2) begin
      mismatched++; $display("FAIL frame_cnt_70 obs=%0d exp=2", frame_cnt_b);
    end
    en_b = 1'b0;
    force u_b.frame_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release u_b.frame_cnt;
    fcb = 16'hFFFF;
    budget = 0;
    do begin
      drive_b(1'b1, 1'b0);
      budget++;
    end while (!sof_b && budget < 40);
    en_b = 1'b0;
    compared++;
    if (!sof_b || frame_cnt_b !== 16'h0000 || fcb !== 16'h0000) begin
      mismatched++;
      $display("FAIL frame_cnt_wrap sof=%b obs=%h exp=0000", sof_b, frame_cnt_b);
    end
  endtask
`endif

  initial begin
    rst_a = 1'b0; en_a = 1'b0; rst_b = 1'b0; en_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_tiny_frame();
    test_tiny_random();
    test_default_lines();
    test_stall();
    test_mid_reset();
`ifdef VTG_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
